// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-addressed data memory port between the
// fetch stage (F) and the memory stage (M). The memory stage wins by default.
// A starvation counter lets fetch in after STARVE_MAX back-to-back memory-stage
// grants, unless m_lock holds the port for a multi-word memory-stage sequence.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              f_req,
    input  logic              f_we,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [15:0]       f_wdata,
    input  logic              f_lb,
    input  logic              f_hb,

    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [15:0]       m_wdata,
    input  logic              m_lb,
    input  logic              m_hb,
    input  logic              m_lock,

    output logic              f_done,
    output logic              m_done,
    output logic [15:0]       f_rdata,
    output logic [15:0]       m_rdata,
    output logic              f_blocked,
    output logic              m_blocked,

    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_lb,
    output logic              mem_hb,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_M = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_reg, state_next;
    logic [3:0]        starve_cnt_reg, starve_cnt_next;
    logic              grant_m, grant_f, complete;

    logic [ADDR_W-1:0] mem_address_reg;
    logic [15:0]       mem_wdata_reg;
    logic              mem_read_reg, mem_write_reg, mem_lb_reg, mem_hb_reg;
    logic              f_done_reg, m_done_reg;
    logic [15:0]       f_rdata_reg, m_rdata_reg;

    // Arbitration, completion detection and starvation bookkeeping.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        grant_m         = 1'b0;
        grant_f         = 1'b0;
        complete        = 1'b0;
        case (state_reg)
            IDLE: begin
                // Memory stage wins unless fetch has waited through STARVE_MAX
                // grants; a lock keeps the memory stage's sequence unbroken.
                if (m_req && (!f_req || m_lock || (starve_cnt_reg < STARVE_LIM))) begin
                    grant_m    = 1'b1;
                    state_next = BUSY_M;
                    if (!f_req) begin
                        starve_cnt_next = 4'd0;
                    end else if (starve_cnt_reg >= STARVE_LIM) begin
                        starve_cnt_next = STARVE_LIM;
                    end else begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end else if (f_req) begin
                    grant_f         = 1'b1;
                    state_next      = BUSY_F;
                    starve_cnt_next = 4'd0;
                end
            end
            BUSY_F, BUSY_M: begin
                if (mem_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Memory-side command: loaded on grant, held during the access, strobes
    // and lanes dropped at completion (address/data simply retained).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_address_reg <= '0;
            mem_wdata_reg   <= 16'd0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_lb_reg      <= 1'b0;
            mem_hb_reg      <= 1'b0;
        end else if (grant_m) begin
            mem_address_reg <= m_addr;
            mem_wdata_reg   <= m_wdata;
            mem_read_reg    <= !m_we;
            mem_write_reg   <= m_we;
            mem_lb_reg      <= m_lb;
            mem_hb_reg      <= m_hb;
        end else if (grant_f) begin
            mem_address_reg <= f_addr;
            mem_wdata_reg   <= f_wdata;
            mem_read_reg    <= !f_we;
            mem_write_reg   <= f_we;
            mem_lb_reg      <= f_lb;
            mem_hb_reg      <= f_hb;
        end else if (complete) begin
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_lb_reg      <= 1'b0;
            mem_hb_reg      <= 1'b0;
        end
    end

    // Requester-side completion: one-cycle done pulse and full-word read data
    // capture (also on writes) for whichever port owned the access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            f_done_reg  <= 1'b0;
            m_done_reg  <= 1'b0;
            f_rdata_reg <= 16'd0;
            m_rdata_reg <= 16'd0;
        end else begin
            f_done_reg <= complete && (state_reg == BUSY_F);
            m_done_reg <= complete && (state_reg == BUSY_M);
            if (complete && (state_reg == BUSY_F)) begin
                f_rdata_reg <= mem_rdata;
            end
            if (complete && (state_reg == BUSY_M)) begin
                m_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_address = mem_address_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_read    = mem_read_reg;
    assign mem_write   = mem_write_reg;
    assign mem_lb      = mem_lb_reg;
    assign mem_hb      = mem_hb_reg;
    assign f_done      = f_done_reg;
    assign m_done      = m_done_reg;
    assign f_rdata     = f_rdata_reg;
    assign m_rdata     = m_rdata_reg;

    // A pending request is blocked whenever its port is not the one in service.
    assign f_blocked   = f_req && (state_reg != BUSY_F);
    assign m_blocked   = m_req && (state_reg != BUSY_M);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations
// followed by randomized requesters, all compared every cycle against a
// transaction-level model of the shared port.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              f_req = 0, f_we = 0, f_lb = 0, f_hb = 0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic [15:0]       f_wdata = '0;
    logic              m_req = 0, m_we = 0, m_lb = 0, m_hb = 0, m_lock = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [15:0]       m_wdata = '0;
    logic              f_done, m_done, f_blocked, m_blocked;
    logic [15:0]       f_rdata, m_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_wdata;
    logic              mem_read, mem_write, mem_lb, mem_hb;
    logic [15:0]       mem_rdata = '0;
    logic              mem_ready = 0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
        .f_lb(f_lb), .f_hb(f_hb),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_lb(m_lb), .m_hb(m_hb), .m_lock(m_lock),
        .f_done(f_done), .m_done(m_done), .f_rdata(f_rdata), .m_rdata(m_rdata),
        .f_blocked(f_blocked), .m_blocked(m_blocked),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_lb(mem_lb), .mem_hb(mem_hb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the shared port ----------------
    // One access in flight at most; its owner, the command the memory sees,
    // each requester's last read word, and how many memory-stage grants fetch
    // has sat through. grant_log records 1 for fetch grants, 2 for memory.
    logic        busy = 0, own_m = 0;
    logic [15:0] e_addr = 0, e_wdata = 0, e_frd = 0, e_mrd = 0;
    logic        e_rd = 0, e_wr = 0, e_lb = 0, e_hb = 0, e_fdone = 0, e_mdone = 0;
    int          waited = 0;
    int          grant_log[$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 0; own_m <= 0; waited <= 0;
            e_addr <= 0; e_wdata <= 0; e_frd <= 0; e_mrd <= 0;
            e_rd <= 0; e_wr <= 0; e_lb <= 0; e_hb <= 0; e_fdone <= 0; e_mdone <= 0;
        end else if (busy) begin
            e_fdone <= mem_ready && !own_m;
            e_mdone <= mem_ready && own_m;
            if (mem_ready) begin
                if (own_m) e_mrd <= mem_rdata;
                else       e_frd <= mem_rdata;
                e_rd <= 0; e_wr <= 0; e_lb <= 0; e_hb <= 0;
                busy <= 0;
            end
        end else begin
            e_fdone <= 0;
            e_mdone <= 0;
            if (m_req && (!f_req || m_lock || waited < STARVE_MAX)) begin
                busy <= 1; own_m <= 1;
                e_addr <= m_addr; e_wdata <= m_wdata;
                e_rd <= !m_we; e_wr <= m_we; e_lb <= m_lb; e_hb <= m_hb;
                waited <= f_req ? ((waited + 1 > STARVE_MAX) ? STARVE_MAX : waited + 1) : 0;
                grant_log.push_back(2);
            end else if (f_req) begin
                busy <= 1; own_m <= 0;
                e_addr <= f_addr; e_wdata <= f_wdata;
                e_rd <= !f_we; e_wr <= f_we; e_lb <= f_lb; e_hb <= f_hb;
                waited <= 0;
                grant_log.push_back(1);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always begin
        @(posedge clock);
        #1;
        check("cyc_mem_address", 32'(mem_address), 32'(e_addr));
        check("cyc_mem_wdata",   32'(mem_wdata),   32'(e_wdata));
        check("cyc_mem_read",    32'(mem_read),    32'(e_rd));
        check("cyc_mem_write",   32'(mem_write),   32'(e_wr));
        check("cyc_mem_lb",      32'(mem_lb),      32'(e_lb));
        check("cyc_mem_hb",      32'(mem_hb),      32'(e_hb));
        check("cyc_f_done",      32'(f_done),      32'(e_fdone));
        check("cyc_m_done",      32'(m_done),      32'(e_mdone));
        check("cyc_f_rdata",     32'(f_rdata),     32'(e_frd));
        check("cyc_m_rdata",     32'(m_rdata),     32'(e_mrd));
        check("cyc_f_blocked",   32'(f_blocked),   32'(f_req && !(busy && !own_m)));
        check("cyc_m_blocked",   32'(m_blocked),   32'(m_req && !(busy && own_m)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic reset_dut();
        @(negedge clock);
        reset_n = 0;
        f_req = 0; m_req = 0; m_lock = 0; mem_ready = 0;
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic new_f();
        f_req = 1; f_we = 1'($urandom_range(0, 1));
        f_addr = 16'($urandom); f_wdata = 16'($urandom);
        f_lb = 1'($urandom_range(0, 1)); f_hb = 1'($urandom_range(0, 1));
    endtask

    task automatic new_m();
        m_req = 1; m_we = 1'($urandom_range(0, 1));
        m_addr = 16'($urandom); m_wdata = 16'($urandom);
        m_lb = 1'($urandom_range(0, 1)); m_hb = 1'($urandom_range(0, 1));
        m_lock = ($urandom_range(0, 3) == 0);
    endtask

    int exp3[6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        // Reset state
        @(posedge clock); #1;
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_f_rdata", 32'(f_rdata), 0);

        // T1: fetch read with ready tied high
        reset_dut();
        mem_ready = 1; mem_rdata = 16'hBEEF;
        f_req = 1; f_we = 0; f_addr = 16'h0010; f_lb = 1; f_hb = 1;
        @(posedge clock); #1;
        check("t1_mem_read", 32'(mem_read), 1);
        check("t1_mem_address", 32'(mem_address), 32'h0010);
        check("t1_f_blocked", 32'(f_blocked), 0);
        @(posedge clock); #1;
        check("t1_f_done", 32'(f_done), 1);
        check("t1_f_rdata", 32'(f_rdata), 32'hBEEF);
        check("t1_strobe_low", 32'(mem_read), 0);
        @(negedge clock); f_req = 0;

        // T2: simultaneous requests, memory stage first
        reset_dut();
        f_req = 1; f_we = 0; f_addr = 16'h0030; f_lb = 1; f_hb = 1;
        m_req = 1; m_we = 1; m_addr = 16'h0020; m_wdata = 16'h1234; m_lb = 1; m_hb = 0;
        @(posedge clock); #1;
        check("t2_mem_write", 32'(mem_write), 1);
        check("t2_mem_lb", 32'(mem_lb), 1);
        check("t2_mem_hb", 32'(mem_hb), 0);
        check("t2_mem_address", 32'(mem_address), 32'h0020);
        check("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
        check("t2_f_blocked", 32'(f_blocked), 1);
        @(negedge clock); mem_ready = 1; mem_rdata = 16'h0BAD;
        @(posedge clock); #1;
        check("t2_m_done", 32'(m_done), 1);
        check("t2_f_blocked_done", 32'(f_blocked), 1);
        @(negedge clock); m_req = 0;
        @(posedge clock); #1;
        check("t2_f_grant_read", 32'(mem_read), 1);
        check("t2_f_grant_addr", 32'(mem_address), 32'h0030);
        @(posedge clock); #1;
        check("t2_f_done", 32'(f_done), 1);
        @(negedge clock); f_req = 0;

        // T3: starvation guard, unlocked
        reset_dut();
        mem_ready = 1;
        m_req = 1; m_lock = 0; m_we = 0; m_addr = 16'h0040; m_lb = 1; m_hb = 1;
        f_req = 1; f_we = 0; f_addr = 16'h0050; f_lb = 1; f_hb = 1;
        grant_log.delete();
        repeat (12) @(negedge clock);
        check("t3_grant_count", 32'(grant_log.size()), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_grant_%0d", i), 32'((grant_log.size() > i) ? grant_log[i] : 0), 32'(exp3[i]));

        // T4: locked memory stage never yields; fetch goes in right after unlock
        reset_dut();
        mem_ready = 1;
        m_req = 1; m_lock = 1; f_req = 1;
        grant_log.delete();
        repeat (12) @(negedge clock);
        check("t4_grant_count", 32'(grant_log.size()), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t4_locked_%0d", i), 32'((grant_log.size() > i) ? grant_log[i] : 0), 2);
        m_lock = 0;
        grant_log.delete();
        repeat (4) @(negedge clock);
        check("t4_unlock_f", 32'((grant_log.size() > 0) ? grant_log[0] : 0), 1);
        f_req = 0; m_req = 0;

        // T5: three wait states on a fetch write
        reset_dut();
        mem_ready = 0;
        f_req = 1; f_we = 1; f_addr = 16'h0077; f_wdata = 16'hCAFE; f_lb = 0; f_hb = 1;
        @(posedge clock); #1;
        check("t5_mem_write", 32'(mem_write), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check($sformatf("t5_hold_addr_%0d", i), 32'(mem_address), 32'h0077);
            check($sformatf("t5_hold_wdata_%0d", i), 32'(mem_wdata), 32'hCAFE);
            check($sformatf("t5_hold_hb_%0d", i), 32'({mem_write, mem_lb, mem_hb}), 32'b101);
            check($sformatf("t5_no_done_%0d", i), 32'(f_done), 0);
        end
        @(negedge clock); mem_ready = 1; mem_rdata = 16'h7E57;
        @(posedge clock); #1;
        check("t5_f_done", 32'(f_done), 1);
        check("t5_f_rdata", 32'(f_rdata), 32'h7E57);
        check("t5_strobe_low", 32'(mem_write), 0);
        @(negedge clock); f_req = 0;
        @(posedge clock); #1;
        check("t5_single_pulse", 32'(f_done), 0);

        // T6: reset in the middle of a memory-stage write
        reset_dut();
        mem_ready = 0;
        m_req = 1; m_we = 1; m_addr = 16'h0099; m_wdata = 16'h4242; m_lb = 1; m_hb = 1; m_lock = 0;
        @(posedge clock); #1;
        check("t6_mem_write", 32'(mem_write), 1);
        @(negedge clock); reset_n = 0;
        #1;
        check("t6_rst_write", 32'(mem_write), 0);
        check("t6_rst_addr", 32'(mem_address), 0);
        check("t6_rst_wdata", 32'(mem_wdata), 0);
        check("t6_rst_lanes", 32'({mem_lb, mem_hb}), 0);
        check("t6_rst_m_done", 32'(m_done), 0);
        check("t6_rst_m_blocked", 32'(m_blocked), 1);
        @(negedge clock); reset_n = 1; mem_ready = 1; mem_rdata = 16'h1111;
        @(posedge clock); #1;
        check("t6_regrant_addr", 32'(mem_address), 32'h0099);
        @(posedge clock); #1;
        check("t6_m_done", 32'(m_done), 1);
        check("t6_m_rdata", 32'(m_rdata), 32'h1111);
        @(negedge clock); m_req = 0;

        // Randomized requesters with random wait states and occasional resets
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = 16'($urandom);
            reset_n   = ($urandom_range(0, 499) != 0);
            if (e_fdone) begin
                if ($urandom_range(0, 1) != 0) new_f(); else f_req = 0;
            end else if (!f_req) begin
                if ($urandom_range(0, 3) == 0) new_f();
            end else if (busy && !own_m && $urandom_range(0, 19) == 0) begin
                f_req = 0;
            end
            if (e_mdone) begin
                if ($urandom_range(0, 2) != 0) new_m(); else begin m_req = 0; m_lock = 0; end
            end else if (!m_req) begin
                if ($urandom_range(0, 2) == 0) new_m();
            end else if (busy && own_m && $urandom_range(0, 19) == 0) begin
                m_req = 0;
            end
        end
        @(negedge clock);
        reset_n = 1;
        @(posedge clock); #2;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
